// File: rtl/marquee_pkg.sv
// marquee_pkg
// Shared definitions for the marquee display engine: character-ROM codes
// and the display mode encoding.
package marquee_pkg;

    // Character-ROM codes (digits 0..9 map to their own value)
    localparam logic [4:0] CH_0     = 5'd0;
    localparam logic [4:0] CH_1     = 5'd1;
    localparam logic [4:0] CH_2     = 5'd2;
    localparam logic [4:0] CH_3     = 5'd3;
    localparam logic [4:0] CH_4     = 5'd4;
    localparam logic [4:0] CH_5     = 5'd5;
    localparam logic [4:0] CH_6     = 5'd6;
    localparam logic [4:0] CH_7     = 5'd7;
    localparam logic [4:0] CH_8     = 5'd8;
    localparam logic [4:0] CH_9     = 5'd9;
    localparam logic [4:0] CH_G     = 5'd16;
    localparam logic [4:0] CH_O     = 5'd22;
    localparam logic [4:0] CH_U     = 5'd27;
    localparam logic [4:0] CH_Z     = 5'd29;
    localparam logic [4:0] CH_BLANK = 5'd31;

    // Display mode, as presented on the mode input
    typedef enum logic {
        MODE_SCROLL = 1'b0,
        MODE_EDIT   = 1'b1
    } mode_e;

endpackage

// File: rtl/marquee_display_rate_tick.sv
// rate_tick
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-low reset
//   clr  - restart the count from zero
//   tick - one-cycle pulse when the count reaches TICK_DIV-1
module rate_tick #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A clear in the terminal cycle suppresses the tick so the first tick
    // after a clear is always a full TICK_DIV cycles away.
    assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/marquee_display.sv
// marquee_display
// Seven-segment text engine: writable message buffer shown as a wrapping
// marquee (scroll mode) or per-digit decimal counters (edit mode).
// Ports:
//   clk, rst           - clock, synchronous active-low reset
//   mode               - 0 scroll, 1 edit
//   direction          - scroll direction, 1 = offset increments
//   btn                - debounced button; rising edge selects next edit digit
//   msg_we/waddr/wdata - message buffer write port
//   addr_bus           - ROM address per digit, digit 0 in MSBs (registered)
//   dp_mask            - one-hot selected digit in edit mode (registered)
//   wrap               - one-cycle pulse when the scroll offset wraps (registered)
module marquee_display
    import marquee_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned MSG_LEN    = 5,
    parameter int unsigned CHAR_W     = 5,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned BLANK_CHAR = 31
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         direction,
    input  logic                         btn,
    input  logic                         msg_we,
    input  logic [$clog2(MSG_LEN)-1:0]   msg_waddr,
    input  logic [CHAR_W-1:0]            msg_wdata,
    output logic [N_DIGITS*CHAR_W-1:0]   addr_bus,
    output logic [N_DIGITS-1:0]          dp_mask,
    output logic                         wrap
);

    localparam int unsigned OFF_W = $clog2(MSG_LEN);
    localparam int unsigned SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CHAR_W-1:0] BLANK    = CHAR_W'(BLANK_CHAR);
    localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(MSG_LEN - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(N_DIGITS - 1);
    localparam logic [OFF_W:0]    LEN_EXT  = (OFF_W+1)'(MSG_LEN);

    logic [CHAR_W-1:0] r_msg [MSG_LEN];
    logic [OFF_W-1:0]  r_offset;
    logic [SEL_W-1:0]  r_sel;
    logic [3:0]        r_val [N_DIGITS];
    logic              r_btn_q;
    mode_e             r_mode_q;
    logic              r_wrap_ev;

    logic [N_DIGITS*CHAR_W-1:0] r_addr_bus;
    logic [N_DIGITS-1:0]        r_dp_mask;
    logic                       r_wrap;

    mode_e                      w_mode;
    logic                       w_clr;
    logic                       w_tick;
    logic                       w_btn_rise;
    logic                       w_waddr_ok;
    logic [N_DIGITS*CHAR_W-1:0] w_addr_next;
    logic [N_DIGITS-1:0]        w_dp_next;
    logic [OFF_W:0]             w_idx;
    logic [CHAR_W-1:0]          w_char;

    assign w_mode     = mode_e'(mode);
    assign w_clr      = (w_mode != r_mode_q);
    assign w_btn_rise = btn && !r_btn_q;
    assign w_waddr_ok = (32'(msg_waddr) < MSG_LEN);

    rate_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // State: message buffer, scroll offset, edit counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < MSG_LEN; k++) begin
                r_msg[k] <= BLANK;
            end
            for (int unsigned k = 0; k < N_DIGITS; k++) begin
                r_val[k] <= '0;
            end
            r_offset  <= '0;
            r_sel     <= '0;
            r_btn_q   <= 1'b0;
            r_mode_q  <= MODE_SCROLL;
            r_wrap_ev <= 1'b0;
        end else begin
            r_btn_q   <= btn;
            r_mode_q  <= w_mode;
            r_wrap_ev <= 1'b0;

            if (msg_we && w_waddr_ok) begin
                r_msg[msg_waddr] <= msg_wdata;
            end

            if (w_mode == MODE_SCROLL) begin
                if (w_tick) begin
                    if (direction) begin
                        if (r_offset == LAST_OFF) begin
                            r_offset  <= '0;
                            r_wrap_ev <= 1'b1;
                        end else begin
                            r_offset <= r_offset + OFF_W'(1);
                        end
                    end else begin
                        if (r_offset == '0) begin
                            r_offset  <= LAST_OFF;
                            r_wrap_ev <= 1'b1;
                        end else begin
                            r_offset <= r_offset - OFF_W'(1);
                        end
                    end
                end
            end else begin
                // Increment uses the pre-edge selection even if btn moves it now
                if (w_tick) begin
                    r_val[r_sel] <= (r_val[r_sel] == 4'd9) ? 4'd0 : r_val[r_sel] + 4'd1;
                end
                if (w_btn_rise) begin
                    r_sel <= (r_sel == LAST_SEL) ? '0 : r_sel + SEL_W'(1);
                end
            end
        end
    end

    // Output mux from registered state
    always_comb begin
        w_addr_next = '0;
        w_dp_next   = '0;
        w_idx       = '0;
        w_char      = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (r_mode_q == MODE_EDIT) begin
                w_char = CHAR_W'(r_val[i]);
            end else begin
                // offset < MSG_LEN and i < MSG_LEN, so one subtract reduces the sum
                w_idx = {1'b0, r_offset} + (OFF_W+1)'(i);
                if (w_idx >= LEN_EXT) begin
                    w_idx = w_idx - LEN_EXT;
                end
                w_char = r_msg[w_idx[OFF_W-1:0]];
            end
            w_addr_next[(N_DIGITS-1-i)*CHAR_W +: CHAR_W] = w_char;
        end
        if (r_mode_q == MODE_EDIT) begin
            w_dp_next[LAST_SEL - r_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr_bus <= {N_DIGITS{BLANK}};
            r_dp_mask  <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_addr_bus <= w_addr_next;
            r_dp_mask  <= w_dp_next;
            r_wrap     <= r_wrap_ev;
        end
    end

    assign addr_bus = r_addr_bus;
    assign dp_mask  = r_dp_mask;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_marquee_display.sv
// tb_marquee_display
// Directed scenarios plus randomized stimulus against a behavioural model
// of the marquee engine; every cycle's outputs are compared with the model.
module tb_marquee_display;

    localparam int ND = 4;
    localparam int ML = 5;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst, mode, direction, btn, msg_we;
    logic [2:0]  msg_waddr;
    logic [4:0]  msg_wdata;
    logic [19:0] addr_bus;
    logic [3:0]  dp_mask;
    logic        wrap;

    int n_cmp = 0;
    int n_bad = 0;

    marquee_display #(
        .N_DIGITS   (ND),
        .MSG_LEN    (ML),
        .CHAR_W     (5),
        .TICK_DIV   (TD),
        .BLANK_CHAR (31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .direction (direction),
        .btn       (btn),
        .msg_we    (msg_we),
        .msg_waddr (msg_waddr),
        .msg_wdata (msg_wdata),
        .addr_bus  (addr_bus),
        .dp_mask   (dp_mask),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: abstract state with modular arithmetic
    int          m_msg [ML];
    int          m_val [ND];
    int          m_off, m_sel, m_pre;
    bit          m_btnq, m_modeq, m_wrapev;
    logic [19:0] e_addr;
    logic [3:0]  e_dp;
    logic        e_wrap;

    function automatic logic [19:0] frame(input int a, input int b, input int c, input int d);
        return {5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    task automatic m_step();
        bit clr, tick;
        int d;
        if (!rst) begin
            foreach (m_msg[k]) m_msg[k] = 31;
            foreach (m_val[k]) m_val[k] = 0;
            m_off = 0; m_sel = 0; m_pre = 0;
            m_btnq = 0; m_modeq = 0; m_wrapev = 0;
            e_addr = frame(31, 31, 31, 31);
            e_dp = 4'b0000;
            e_wrap = 1'b0;
            return;
        end
        // outputs reflect the state held before this edge
        for (int i = 0; i < ND; i++) begin
            d = m_modeq ? m_val[i] : m_msg[(m_off + i) % ML];
            e_addr[(ND-1-i)*5 +: 5] = 5'(d);
        end
        e_dp   = m_modeq ? (4'b1000 >> m_sel) : 4'b0000;
        e_wrap = m_wrapev;

        clr   = (mode != m_modeq);
        tick  = !clr && (m_pre == TD - 1);
        m_pre = clr ? 0 : (m_pre + 1) % TD;

        if (msg_we && int'(msg_waddr) < ML) m_msg[msg_waddr] = int'(msg_wdata);

        m_wrapev = 0;
        if (!mode) begin
            if (tick) begin
                if (direction) begin
                    m_off = (m_off + 1) % ML;
                    m_wrapev = (m_off == 0);
                end else begin
                    m_off = (m_off + ML - 1) % ML;
                    m_wrapev = (m_off == ML - 1);
                end
            end
        end else begin
            if (tick) m_val[m_sel] = (m_val[m_sel] + 1) % 10;
            if (btn && !m_btnq) m_sel = (m_sel + 1) % ND;
        end
        m_btnq  = btn;
        m_modeq = mode;
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        #1;
        chk("addr_bus", 32'(addr_bus), 32'(e_addr));
        chk("dp_mask", 32'(dp_mask), 32'(e_dp));
        chk("wrap", 32'(wrap), 32'(e_wrap));
    endtask

    // Advance until the displayed frame changes (bounded)
    task automatic wait_frame();
        logic [19:0] prev;
        prev = addr_bus;
        for (int n = 0; n < 16; n++) begin
            cycle();
            if (addr_bus !== prev) break;
        end
    endtask

    logic [19:0] exp_frames [5];
    int          msg_init [5] = '{22, 16, 27, 29, 0};

    initial begin
        rst = 1'b0; mode = 1'b0; direction = 1'b1; btn = 1'b0;
        msg_we = 1'b0; msg_waddr = '0; msg_wdata = '0;
        repeat (3) cycle();
        chk("reset_addr", 32'(addr_bus), 32'(frame(31, 31, 31, 31)));
        chk("reset_dp", 32'(dp_mask), 32'd0);
        rst = 1'b1;

        // Load message while in edit mode so the offset stays at 0
        mode = 1'b1;
        cycle();
        for (int k = 0; k < 5; k++) begin
            msg_we = 1'b1; msg_waddr = 3'(k); msg_wdata = 5'(msg_init[k]);
            cycle();
        end
        msg_we = 1'b0;

        // Scroll left through a full revolution
        mode = 1'b0;
        cycle();
        cycle();
        chk("scroll_f0", 32'(addr_bus), 32'(frame(22, 16, 27, 29)));
        exp_frames[0] = frame(16, 27, 29, 0);
        exp_frames[1] = frame(27, 29, 0, 22);
        exp_frames[2] = frame(29, 0, 22, 16);
        exp_frames[3] = frame(0, 22, 16, 27);
        exp_frames[4] = frame(22, 16, 27, 29);
        for (int k = 0; k < 5; k++) begin
            wait_frame();
            chk("scroll_frame", 32'(addr_bus), 32'(exp_frames[k]));
            chk("scroll_wrap", 32'(wrap), (k == 4) ? 32'd1 : 32'd0);
        end
        cycle();
        chk("wrap_one_cycle", 32'(wrap), 32'd0);

        // Reverse direction from offset 0, then alternate
        direction = 1'b0;
        wait_frame();
        chk("rev_frame", 32'(addr_bus), 32'(frame(0, 22, 16, 27)));
        chk("rev_wrap", 32'(wrap), 32'd1);
        direction = 1'b1;
        wait_frame();
        chk("alt_frame_a", 32'(addr_bus), 32'(frame(22, 16, 27, 29)));
        direction = 1'b0;
        wait_frame();
        chk("alt_frame_b", 32'(addr_bus), 32'(frame(0, 22, 16, 27)));

        // Edit mode digit selection
        mode = 1'b1;
        cycle();
        cycle();
        chk("edit_dp0", 32'(dp_mask), 32'b1000);
        btn = 1'b1; cycle();
        btn = 1'b0; cycle();
        chk("edit_dp1", 32'(dp_mask), 32'b0100);
        btn = 1'b1; repeat (3) cycle();
        btn = 1'b0; cycle();
        chk("edit_hold_btn", 32'(dp_mask), 32'b0010);
        repeat (12) cycle();

        // Out-of-range write, then reset mid-run
        mode = 1'b0; msg_we = 1'b1; msg_waddr = 3'd7; msg_wdata = 5'd3;
        cycle();
        msg_we = 1'b0;
        repeat (6) cycle();
        rst = 1'b0;
        cycle();
        chk("midreset_addr", 32'(addr_bus), 32'(frame(31, 31, 31, 31)));
        chk("midreset_dp", 32'(dp_mask), 32'd0);
        chk("midreset_wrap", 32'(wrap), 32'd0);
        rst = 1'b1;

        // Randomized phases with different stimulus mixes
        for (int seg = 0; seg < 4; seg++) begin
            for (int n = 0; n < 300; n++) begin
                rst       = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, (seg == 2) ? 3 : 40) == 0) mode = ~mode;
                if ($urandom_range(0, 15) == 0) direction = ~direction;
                btn       = (seg == 1) ? 1'($urandom_range(0, 1)) : (($urandom_range(0, 7) == 0) ? ~btn : btn);
                msg_we    = ($urandom_range(0, (seg == 3) ? 1 : 6) == 0);
                msg_waddr = 3'($urandom_range(0, 7));
                msg_wdata = 5'($urandom);
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/marquee_display.md
Name: marquee_display

Overview:
Parametrised seven-segment text engine sitting between the board controls and the character ROM / scan unit.
- Holds a writable message buffer of MSG_LEN character codes.
- Drives N_DIGITS character-ROM addresses in one of two modes:
  - scroll mode: a marquee scrolling left or right with wrap-around;
  - edit mode: per-digit decimal counters, with button-driven digit selection.
- Replaces the hard-coded scroll FSM of the lab top level. The message is loaded at run time, and scroll rate and digit count are generic.

Parameters:
N_DIGITS, 4, number of display digits driven.
MSG_LEN, 5, message buffer depth in characters (>= N_DIGITS, >= 2).
CHAR_W, 5, character-ROM address width.
TICK_DIV, 50000000, clk cycles per scroll/edit step (>= 2).
BLANK_CHAR, 31, ROM code shown for blank; reset fill value.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset.
mode  in  1  0 = scroll, 1 = edit.
direction  in  1  scroll direction: 1 = offset increments, 0 = offset decrements.
btn  in  1  debounced level button; rising edge advances edit digit.
msg_we  in  1  message write strobe.
msg_waddr  in  clog2(MSG_LEN)  message write index.
msg_wdata  in  CHAR_W  character code to write.
addr_bus  out  N_DIGITS*CHAR_W  ROM address per digit; digit 0 (leftmost) in MSBs.
dp_mask  out  N_DIGITS  one-hot selected digit in edit mode, 0 in scroll mode; digit 0 in MSB.
wrap  out  1  one-cycle pulse when the scroll offset wraps.

Behaviour:
- Reset (rst==0 at clk edge):
  - msg buffer all BLANK_CHAR; offset=0; edit_sel=0; all edit values=0; prescaler=0; btn edge register=0.
  - addr_bus all BLANK_CHAR; dp_mask=0; wrap=0.
- Reset mid-operation aborts everything in that cycle; pending writes are discarded.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1, then returns to 0.
  - Any change of mode (registered compare) clears the prescaler, so the first tick after a switch comes TICK_DIV cycles later.
- Message write:
  - msg_we=1 with msg_waddr<MSG_LEN writes msg_wdata at the clock edge, in either mode.
  - msg_waddr>=MSG_LEN is ignored.
  - Write and tick in the same cycle: the write takes effect; display picks it up on the next output update.
- Scroll mode, on tick:
  - direction=1: offset = (offset==MSG_LEN-1) ? 0 : offset+1; wrap=1 when the new offset is 0.
  - direction=0: offset = (offset==0) ? MSG_LEN-1 : offset-1; wrap=1 when the new offset is MSG_LEN-1.
  - Digit i shows msg[(offset+i) mod MSG_LEN].
- Edit mode:
  - btn rising edge (btn=1 now, 0 last cycle): edit_sel = (edit_sel==N_DIGITS-1) ? 0 : edit_sel+1.
  - On tick: value[edit_sel] = (value==9) ? 0 : value+1. Values are 4-bit, and ROM codes 0..9 are the digits.
  - Digit i shows value[i] zero-extended to CHAR_W. dp_mask bit for edit_sel is 1.
  - Tick and btn edge in the same cycle: the increment applies to the old edit_sel, and the selection moves in the same edge.
- State retention: offset is retained while in edit mode; edit values and edit_sel are retained while in scroll mode.
- Output timing:
  - addr_bus, dp_mask and wrap are registered, with one-cycle latency from the state/buffer update to the outputs.
  - The downstream ROM adds its own cycle.
- Reductions: no division hardware. (offset+i) mod MSG_LEN uses a single conditional subtract, valid because offset<MSG_LEN and i<N_DIGITS<=MSG_LEN.

Decomposition:
- Package marquee_pkg holds:
  - character code constants CH_0..CH_9, CH_G=16, CH_O=22, CH_U=27, CH_Z=29, CH_BLANK=31;
  - the mode encoding constants MODE_SCROLL=0, MODE_EDIT=1.
- One sub-module, rate_tick: parametrised prescaler with clk, rst, clr inputs and a tick output; TICK_DIV is its generic.
- Message buffer, scroll offset, edit counters and output mux stay in marquee_display.

Test Plan:
Common setup: TICK_DIV=4, N_DIGITS=4, MSG_LEN=5. Write msg = 22,16,27,29,0.
1. Reset, then write the message, mode=0, direction=1. After reset addr_bus = 31,31,31,31. After writes, before the first tick: 22,16,27,29. After successive ticks: 16,27,29,0; then 27,29,0,22; then 29,0,22,16; then 0,22,16,27; then 22,16,27,29 with wrap=1 for exactly one cycle.
2. From offset 0 with direction=0, one tick -> 0,22,16,27, offset=4, wrap=1. Toggle direction each tick -> display alternates between two frames.
3. mode=1, no btn, 10 ticks -> value0 sequence 1..9,0, display d,0,0,0, dp_mask=1000. btn pulse -> dp_mask=0100. Three more btn edges -> dp_mask back to 1000. Holding btn high gives only one advance.
4. Tick and btn rising edge in the same cycle with edit_sel=0 and value0=3 -> value0=4, edit_sel=1.
5. Switch mode 0->1->0 mid-count -> offset and edit values preserved; first tick after each switch exactly 4 cycles later.
6. msg_we with msg_waddr=7 -> no change. Write msg[1]=31 during scroll -> visible on the next output update. Assert rst=0 mid-scroll -> all outputs BLANK/0 on the next cycle.
